// File: rtl/mk_design_param_pkg.sv
// Shared definitions for mk_design_param: operator encodings, a
// constant-foldable ceil-log2 and the default data word type.
package mk_design_param_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_XOR = 2;

  localparam int DEFAULT_W = 9;
  typedef logic [DEFAULT_W-1:0] data_t;

  // Evaluated at elaboration to size pointers from DEPTH
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mk_design_param_if.sv
// Method-port bundle for mk_design_param: start/result/check/errors
// argument ports plus their EN_/RDY_ strobes.
interface mk_design_param_if #(
  parameter int W     = 9,
  parameter int ERR_W = 8
);

  logic [W-1:0]     start_st_a;
  logic [W-1:0]     start_st_b;
  logic             EN_start;
  logic             RDY_start;
  logic [W-1:0]     result_st_c;
  logic [W-1:0]     result;
  logic             RDY_result;
  logic [W-1:0]     check_st_d;
  logic             EN_check;
  logic [W-1:0]     check;
  logic             RDY_check;
  logic [ERR_W-1:0] errors;
  logic             RDY_errors;

  modport master (
    output start_st_a, start_st_b, EN_start, result_st_c, check_st_d, EN_check,
    input  RDY_start, result, RDY_result, check, RDY_check, errors, RDY_errors
  );

  modport slave (
    input  start_st_a, start_st_b, EN_start, result_st_c, check_st_d, EN_check,
    output RDY_start, result, RDY_result, check, RDY_check, errors, RDY_errors
  );

endinterface

// File: rtl/mk_design_param_sync_fifo_ptr.sv
// Read/write pointers and occupancy for a DEPTH-entry circular buffer.
// push_i/pop_i must already be qualified by full_o/empty_o.
module mk_design_param_sync_fifo_ptr
  import mk_design_param_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  output logic [clog2(DEPTH)-1:0]   wrPtr_o,
  output logic [clog2(DEPTH)-1:0]   rdPtr_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers wrap for free because DEPTH is a power of two
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (push_i) wrPtr_d = wrPtr_q + 1'b1;
    if (pop_i)  rdPtr_d = rdPtr_q + 1'b1;
    if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wrPtr_o = wrPtr_q;
  assign rdPtr_o = rdPtr_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mk_design_param.sv
// Queue of start results (a OP b) consumed by check, which compares the
// head against d and keeps a saturating mismatch count.
module mk_design_param
  import mk_design_param_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  parameter int OP    = 0,
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  mk_design_param_if.slave mif
);

  localparam int PW = clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             full;
  logic             empty;
  logic             pushFire;
  logic             popFire;
  logic [W-1:0]     head;
  logic [W-1:0]     opValue;
  logic [ERR_W-1:0] errCnt_q, errCnt_d;

  // Ready depends only on registered occupancy, so no path from EN_* to RDY_*
  assign pushFire = mif.EN_start && !full;
  assign popFire  = mif.EN_check && !empty;

  mk_design_param_sync_fifo_ptr #(.DEPTH(DEPTH)) uPtr (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (pushFire),
    .pop_i   (popFire),
    .wrPtr_o (wrPtr),
    .rdPtr_o (rdPtr),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    opValue = mif.start_st_a + mif.start_st_b;
    case (OP)
      OP_SUB:  opValue = mif.start_st_a - mif.start_st_b;
      OP_XOR:  opValue = mif.start_st_a ^ mif.start_st_b;
      default: ;
    endcase
  end

  // Storage is deliberately left unreset; occupancy alone defines validity
  always_ff @(posedge CLK) begin
    if (pushFire) mem_q[wrPtr] <= opValue;
  end

  assign head = mem_q[rdPtr];

  always_comb begin
    errCnt_d = errCnt_q;
    if (popFire && (head != mif.check_st_d) && (errCnt_q != '1))
      errCnt_d = errCnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) errCnt_q <= '0;
    else        errCnt_q <= errCnt_d;
  end

  assign mif.RDY_start  = !full;
  assign mif.RDY_result = !empty;
  assign mif.RDY_check  = !empty;
  assign mif.RDY_errors = 1'b1;
  assign mif.result     = empty ? '0 : head + mif.result_st_c;
  assign mif.check      = empty ? '0 : head - mif.check_st_d;
  assign mif.errors     = errCnt_q;

endmodule

// File: tb/tb_mk_design_param.sv
// Directed bench for mk_design_param: vector table on the default build,
// hand sequences for reset, saturation (ERR_W=2, OP=1) and XOR.
module tb_mk_design_param;

  typedef struct {
    logic       es;
    logic [8:0] a;
    logic [8:0] b;
    logic       ec;
    logic [8:0] c;
    logic [8:0] d;
    logic       rs;
    logic       rr;
    logic [8:0] res;
    logic [8:0] chk;
    logic [7:0] err;
  } vec_t;

  logic CLK;
  logic RST_N;
  int   checkCount;
  int   errorCount;
  vec_t vecs[$];

  mk_design_param_if #(.W(9), .ERR_W(8)) ifA ();
  mk_design_param_if #(.W(9), .ERR_W(2)) ifB ();
  mk_design_param_if #(.W(9), .ERR_W(8)) ifC ();

  mk_design_param #(.W(9), .DEPTH(4), .OP(0), .ERR_W(8)) dutA (
    .CLK(CLK), .RST_N(RST_N), .mif(ifA.slave));
  mk_design_param #(.W(9), .DEPTH(4), .OP(1), .ERR_W(2)) dutB (
    .CLK(CLK), .RST_N(RST_N), .mif(ifB.slave));
  mk_design_param #(.W(9), .DEPTH(4), .OP(2), .ERR_W(8)) dutC (
    .CLK(CLK), .RST_N(RST_N), .mif(ifC.slave));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mk(input int es, input int a, input int b, input int ec,
                              input int c, input int d, input int rs, input int rr,
                              input int res, input int chk, input int err);
    vec_t v;
    v.es  = 1'(es);
    v.a   = 9'(a);
    v.b   = 9'(b);
    v.ec  = 1'(ec);
    v.c   = 9'(c);
    v.d   = 9'(d);
    v.rs  = 1'(rs);
    v.rr  = 1'(rr);
    v.res = 9'(res);
    v.chk = 9'(chk);
    v.err = 8'(err);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ifA.EN_start    = v.es;
    ifA.start_st_a  = v.a;
    ifA.start_st_b  = v.b;
    ifA.EN_check    = v.ec;
    ifA.result_st_c = v.c;
    ifA.check_st_d  = v.d;
  endtask

  task automatic checkVector(input vec_t v, input int idx);
    checkOutput("A.RDY_start",  idx, 32'(ifA.RDY_start),  32'(v.rs));
    checkOutput("A.RDY_result", idx, 32'(ifA.RDY_result), 32'(v.rr));
    checkOutput("A.RDY_check",  idx, 32'(ifA.RDY_check),  32'(v.rr));
    checkOutput("A.result",     idx, 32'(ifA.result),     32'(v.res));
    checkOutput("A.check",      idx, 32'(ifA.check),      32'(v.chk));
    checkOutput("A.errors",     idx, 32'(ifA.errors),     32'(v.err));
  endtask

  task automatic idleAll();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    ifB.EN_start = 1'b0; ifB.start_st_a = '0; ifB.start_st_b = '0;
    ifB.EN_check = 1'b0; ifB.result_st_c = '0; ifB.check_st_d = '0;
    ifC.EN_start = 1'b0; ifC.start_st_a = '0; ifC.start_st_b = '0;
    ifC.EN_check = 1'b0; ifC.result_st_c = '0; ifC.check_st_d = '0;
  endtask

  initial begin
    int expErr;
    checkCount = 0;
    errorCount = 0;
    RST_N = 1'b0;
    idleAll();

    // Basic start/check, full queue, ignored enables, wrap, simultaneous push/pop
    vecs.push_back(mk(0, 0,     0, 0, 1, 0,   1, 0, 0,  0,     0));
    vecs.push_back(mk(1, 3,     5, 0, 1, 0,   1, 0, 0,  0,     0));
    vecs.push_back(mk(0, 0,     0, 1, 1, 8,   1, 1, 9,  0,     0));
    vecs.push_back(mk(0, 0,     0, 1, 1, 5,   1, 0, 0,  0,     0));
    vecs.push_back(mk(1, 1,     0, 0, 0, 0,   1, 0, 0,  0,     0));
    vecs.push_back(mk(1, 2,     0, 0, 0, 0,   1, 1, 1,  1,     0));
    vecs.push_back(mk(1, 3,     0, 0, 0, 0,   1, 1, 1,  1,     0));
    vecs.push_back(mk(1, 4,     0, 0, 0, 0,   1, 1, 1,  1,     0));
    vecs.push_back(mk(1, 5,     0, 0, 0, 0,   0, 1, 1,  1,     0));
    vecs.push_back(mk(0, 0,     0, 1, 0, 1,   0, 1, 1,  0,     0));
    vecs.push_back(mk(0, 0,     0, 1, 0, 2,   1, 1, 2,  0,     0));
    vecs.push_back(mk(0, 0,     0, 1, 0, 3,   1, 1, 3,  0,     0));
    vecs.push_back(mk(0, 0,     0, 1, 0, 4,   1, 1, 4,  0,     0));
    vecs.push_back(mk(0, 0,     0, 0, 0, 0,   1, 0, 0,  0,     0));
    vecs.push_back(mk(1, 'h1FF, 2, 0, 0, 0,   1, 0, 0,  0,     0));
    vecs.push_back(mk(0, 0,     0, 1, 0, 3,   1, 1, 1,  'h1FE, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0, 0,   1, 0, 0,  0,     1));
    vecs.push_back(mk(1, 10,    0, 0, 0, 0,   1, 0, 0,  0,     1));
    vecs.push_back(mk(1, 20,    0, 0, 0, 0,   1, 1, 10, 10,    1));
    vecs.push_back(mk(1, 30,    0, 1, 0, 10,  1, 1, 10, 0,     1));
    vecs.push_back(mk(0, 0,     0, 0, 0, 0,   1, 1, 20, 20,    1));
    vecs.push_back(mk(0, 0,     0, 1, 0, 20,  1, 1, 20, 0,     1));
    vecs.push_back(mk(0, 0,     0, 1, 0, 30,  1, 1, 30, 0,     1));
    vecs.push_back(mk(0, 0,     0, 0, 0, 0,   1, 0, 0,  0,     1));

    #1;
    checkOutput("reset RDY_start",  0, 32'(ifA.RDY_start),  32'd1);
    checkOutput("reset RDY_result", 0, 32'(ifA.RDY_result), 32'd0);
    checkOutput("reset RDY_check",  0, 32'(ifA.RDY_check),  32'd0);
    checkOutput("reset errors",     0, 32'(ifA.errors),     32'd0);
    checkOutput("reset RDY_errors", 0, 32'(ifA.RDY_errors), 32'd1);
    checkOutput("reset result",     0, 32'(ifA.result),     32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i]);
      #1;
      checkVector(vecs[i], i);
    end

    // Reset pulse between edges with three entries queued
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      applyStimulus(mk(1, 7 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    @(negedge CLK);
    idleAll();
    #1;
    checkOutput("pre-reset head", 100, 32'(ifA.result), 32'd7);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("midreset RDY_result", 101, 32'(ifA.RDY_result), 32'd0);
    checkOutput("midreset RDY_start",  101, 32'(ifA.RDY_start),  32'd1);
    checkOutput("midreset errors",     101, 32'(ifA.errors),     32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    applyStimulus(mk(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    applyStimulus(mk(0, 0, 0, 1, 0, 11, 0, 0, 0, 0, 0));
    #1;
    checkOutput("post-reset RDY_result", 102, 32'(ifA.RDY_result), 32'd1);
    checkOutput("post-reset result",     102, 32'(ifA.result),     32'd11);
    checkOutput("post-reset check",      102, 32'(ifA.check),      32'd0);
    @(negedge CLK);
    idleAll();
    #1;
    checkOutput("post-reset drained", 103, 32'(ifA.RDY_check), 32'd0);

    // Subtract operator with a 2-bit saturating error counter
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      ifB.EN_start = 1'b1; ifB.start_st_a = 9'd2; ifB.start_st_b = 9'd5;
      @(negedge CLK);
      ifB.EN_start = 1'b0;
      ifB.EN_check = 1'b1; ifB.check_st_d = 9'd0; ifB.result_st_c = 9'd3;
      #1;
      checkOutput("B.check sub", 200 + i, 32'(ifB.check),  32'h1FD);
      checkOutput("B.result",    200 + i, 32'(ifB.result), 32'h000);
      @(negedge CLK);
      ifB.EN_check = 1'b0;
      #1;
      expErr = (i + 1 > 3) ? 3 : i + 1;
      checkOutput("B.errors sat", 200 + i, 32'(ifB.errors), 32'(expErr));
      checkOutput("B.RDY_check",  200 + i, 32'(ifB.RDY_check), 32'd0);
    end

    // XOR operator
    @(negedge CLK);
    ifC.EN_start = 1'b1; ifC.start_st_a = 9'h0F0; ifC.start_st_b = 9'h0FF;
    @(negedge CLK);
    ifC.EN_start = 1'b0;
    ifC.EN_check = 1'b1; ifC.check_st_d = 9'h00F; ifC.result_st_c = 9'd1;
    #1;
    checkOutput("C.check xor",  300, 32'(ifC.check),  32'h000);
    checkOutput("C.result xor", 300, 32'(ifC.result), 32'h010);
    @(negedge CLK);
    ifC.EN_check = 1'b0;
    #1;
    checkOutput("C.errors",    301, 32'(ifC.errors),    32'd0);
    checkOutput("C.RDY_check", 301, 32'(ifC.RDY_check), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
